// File: rtl/trace_buffer.sv
// trace_buffer: FIFO stage between trace_unit and the trace sink.
// Holds trace records until the sink accepts them over valid/ready.
// Records that arrive while the buffer is full are dropped and counted.
// Optional feature macro: TRACE_BUFFER_HWM_EN adds a high-water-mark output hwm_o.
module trace_buffer #(
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trace_data_ready,
  input  logic [DATA_WIDTH-1:0]   trace_data_i,
  output logic                    trace_valid_o,
  output logic [DATA_WIDTH-1:0]   trace_data_o,
  input  logic                    trace_accept_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    overflow_o,
  output logic [CNT_WIDTH-1:0]    dropped_count_o,
`ifdef TRACE_BUFFER_HWM_EN
  output logic [$clog2(DEPTH):0]  hwm_o,
`endif
  input  logic                    clear_overflow_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]         level;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic                  head_load;
  logic                  overflow_reg, overflow_next;
  logic [CNT_WIDTH-1:0]  drop_cnt_reg, drop_cnt_next;
  logic                  empty, full;
  logic                  push, pop, drop;

  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));

  // Handshake decode: a pop on a full buffer frees the slot for a same-edge push.
  always_comb begin
    pop  = !empty && trace_accept_i;
    push = trace_data_ready && (!full || pop);
    drop = trace_data_ready && full && !pop;
  end

  // Next pointers, next head record and sticky overflow bookkeeping.
  always_comb begin
    rd_ptr_next   = rd_ptr_reg + PW'(pop);
    wr_ptr_next   = wr_ptr_reg + PW'(push);
    head_load     = pop || (push && empty);
    // The next head is the incoming record when it lands in the slot about to
    // become the head (empty buffer, or a single record being popped).
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = trace_data_i;
    end else begin
      head_next = mem[rd_ptr_next[AW-1:0]];
    end
    overflow_next = overflow_reg;
    drop_cnt_next = drop_cnt_reg;
    if (clear_overflow_i) begin
      overflow_next = 1'b0;
      drop_cnt_next = '0;
    end else if (drop) begin
      overflow_next = 1'b1;
      if (drop_cnt_reg != '1) begin
        drop_cnt_next = drop_cnt_reg + 1'b1;
      end
    end
  end

  // Record storage: no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= trace_data_i;
    end
  end

  // Control state and the registered head record.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
      if (head_load) begin
        head_reg <= head_next;
      end
    end
  end

`ifdef TRACE_BUFFER_HWM_EN
  logic [PW-1:0] hwm_reg;
  logic [PW-1:0] level_next;

  assign level_next = wr_ptr_next - rd_ptr_next;

  // High-water mark tracks the post-edge level; a clear reloads it from that level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_reg <= '0;
    end else if (clear_overflow_i || (level_next > hwm_reg)) begin
      hwm_reg <= level_next;
    end
  end

  assign hwm_o = hwm_reg;
`endif

  assign trace_valid_o   = !empty;
  assign trace_data_o    = head_reg;
  assign level_o         = level;
  assign full_o          = full;
  assign overflow_o      = overflow_reg;
  assign dropped_count_o = drop_cnt_reg;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus random traffic,
// compared against a queue-based reference model of the buffer.
module tb_trace_buffer;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int DW      = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  trace_data_ready = 1'b0;
  logic [DW-1:0]         trace_data_i = '0;
  logic                  trace_valid_o;
  logic [DW-1:0]         trace_data_o;
  logic                  trace_accept_i = 1'b0;
  logic [$clog2(DEPTH):0] level_o;
  logic                  full_o;
  logic                  overflow_o;
  logic [CNT_W-1:0]      dropped_count_o;
  logic                  clear_overflow_i = 1'b0;
`ifdef TRACE_BUFFER_HWM_EN
  logic [$clog2(DEPTH):0] hwm_o;
`endif

  trace_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_W), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .trace_data_ready (trace_data_ready),
    .trace_data_i     (trace_data_i),
    .trace_valid_o    (trace_valid_o),
    .trace_data_o     (trace_data_o),
    .trace_accept_i   (trace_accept_i),
    .level_o          (level_o),
    .full_o           (full_o),
    .overflow_o       (overflow_o),
    .dropped_count_o  (dropped_count_o),
`ifdef TRACE_BUFFER_HWM_EN
    .hwm_o            (hwm_o),
`endif
    .clear_overflow_i (clear_overflow_i)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;
  int cyc = 0;

  // Reference model state.
  logic [DW-1:0] model_q[$];
  bit            model_ovf = 0;
  int            model_cnt = 0;
  int            model_hwm = 0;
  logic [DW-1:0] exp_data = '0;
  bit            data_known = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic step(input bit r, input bit rdy, input logic [DW-1:0] d,
                      input bit acc, input bit clr);
    int  sz;
    bit  m_pop, m_push, m_drop;
    rst              = r;
    trace_data_ready = rdy;
    trace_data_i     = d;
    trace_accept_i   = acc;
    clear_overflow_i = clr;
    sz     = model_q.size();
    m_pop  = (sz > 0) && acc;
    m_push = rdy && ((sz < DEPTH) || m_pop);
    m_drop = rdy && (sz == DEPTH) && !m_pop;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      model_q.delete();
      model_ovf  = 0;
      model_cnt  = 0;
      model_hwm  = 0;
      exp_data   = '0;
      data_known = 1;
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
      if (clr) begin
        model_ovf = 0;
        model_cnt = 0;
        model_hwm = model_q.size();
      end else begin
        if (m_drop) begin
          model_ovf = 1;
          if (model_cnt < CNT_MAX) model_cnt++;
        end
        if (model_q.size() > model_hwm) model_hwm = model_q.size();
      end
      if (model_q.size() > 0) begin
        exp_data   = model_q[0];
        data_known = 1;
      end else if (m_pop) begin
        data_known = 0;
      end
    end
    $display("cyc %0d rst=%0b rdy=%0b acc=%0b clr=%0b din=%h -> level=%0d valid=%0b head=%h ovf=%0b drops=%0d",
             cyc, r, rdy, acc, clr, d, level_o, trace_valid_o, trace_data_o, overflow_o, dropped_count_o);
    check_eq("level", 64'(level_o), 64'(model_q.size()));
    check_eq("valid", 64'(trace_valid_o), 64'(model_q.size() > 0));
    check_eq("full", 64'(full_o), 64'(model_q.size() == DEPTH));
    check_eq("overflow", 64'(overflow_o), 64'(model_ovf));
    check_eq("dropped", 64'(dropped_count_o), 64'(model_cnt));
    if (data_known) check_eq("head", 64'(trace_data_o), 64'(exp_data));
`ifdef TRACE_BUFFER_HWM_EN
    check_eq("hwm", 64'(hwm_o), 64'(model_hwm));
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0);
  endtask

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) step(0, 1, $urandom, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) step(0, 0, '0, 1, 0);
  endtask

  initial begin
    // Reset state.
    step(1, 0, '0, 0, 0);
    step(1, 1, 32'hdead_beef, 1, 0);

    // Single record A with accept held: visible next cycle, then consumed.
    step(0, 1, 32'ha5a5_0001, 1, 0);
    check_eq("t1_head_A", 64'(trace_data_o), 64'h a5a5_0001);
    step(0, 0, '0, 1, 0);
    idle(1);

    // Fill, then three overflow pushes; head must stay put.
    push_n(DEPTH);
    push_n(3);
    check_eq("t2_drops", 64'(dropped_count_o), 64'd3);

    // Full buffer with push and accept together: no drop.
    for (int k = 0; k < 4; k++) step(0, 1, $urandom, 1, 0);
    drain();

    // Streamed records with alternating push/accept across pointer wrap.
    for (int k = 0; k < 40; k++) step(0, (k % 2) == 0, $urandom, (k % 2) == 1, 0);
    drain();

    // Counter saturation.
    push_n(DEPTH);
    push_n(CNT_MAX + 5);
    step(0, 1, $urandom, 0, 1);
    drain();

    // Reset mid-operation with level 5 and overflow set.
    push_n(DEPTH + 1);
    for (int k = 0; k < 3; k++) step(0, 0, '0, 1, 0);
    step(1, 0, '0, 0, 0);
    idle(1);
    // Clear in the same cycle as a drop: the drop is not counted.
    push_n(DEPTH);
    step(0, 1, $urandom, 0, 1);
    drain();

`ifdef TRACE_BUFFER_HWM_EN
    push_n(6);
    drain();
    push_n(2);
    step(0, 0, '0, 0, 1);
    drain();
`endif

    // Random traffic: producer-heavy first half, sink-heavy second half.
    for (int i = 0; i < 500; i++) begin
      bit r, rdy, acc, clr;
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 99) < (i < 250 ? 75 : 40));
      acc = ($urandom_range(0, 99) < (i < 250 ? 40 : 75));
      clr = ($urandom_range(0, 31) == 0);
      step(r, rdy, $urandom, acc, clr);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
